// File: rtl/fmap_pingpong_buffer_pkg.sv
// ============================================================================
//  Module      : fmap_pingpong_buffer_pkg
//  Description : Shared constants and state encodings for the feature-map
//                ping-pong buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fmap_pingpong_buffer_pkg;

    localparam int FEATURE_MAP_RESOLUTION = 8;
    localparam int FEATURE_MAP_ADDRWIDE   = 9;
    localparam int FMAP_IMG_W             = 29;
    localparam int FMAP_IMG_H             = 13;
    localparam int FMAP_TOTAL_PIXELS      = FMAP_IMG_W * FMAP_IMG_H;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_FETCH  = 2'd1,
        R_STREAM = 2'd2
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/fmap_pingpong_buffer_ram.sv
// ============================================================================
//  Module      : ram_simple_dual_one_clock
//  Description : Simple dual-port RAM, one write port and one registered read
//                port (1-cycle latency) on a single clock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_simple_dual_one_clock #(
    parameter int WIDTH     = 8,
    parameter int SIZE      = 1024,
    parameter int ADDRWIDTH = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic [ADDRWIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]     wr_data_i,
    input  logic                 rd_en_i,
    input  logic [ADDRWIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]     rd_data_o
);

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register holds its value while rd_en_i is low; the streaming
    // side relies on this to keep output data stable under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/fmap_pingpong_buffer.sv
// ============================================================================
//  Module      : fmap_pingpong_buffer
//  Description : Two-bank frame buffer: captures a quantized feature-map
//                stream and replays complete frames in raster order over a
//                valid/ready interface. Optional FMAP_PINGPONG_STATS_EN adds
//                saturating frame and drop counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmap_pingpong_buffer
    import fmap_pingpong_buffer_pkg::*;
#(
    parameter int REC_IMG_W = FMAP_IMG_W,
    parameter int REC_IMG_H = FMAP_IMG_H,
    parameter int DATA_W    = FEATURE_MAP_RESOLUTION,
    parameter int ADDR_W    = FEATURE_MAP_ADDRWIDE
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
`ifdef FMAP_PINGPONG_STATS_EN
    output logic [15:0]       frames_out_o,
    output logic [15:0]       drops_o,
`endif
    output logic              drop_o
);

    localparam int              TOTAL_PIXELS = REC_IMG_W * REC_IMG_H;
    localparam logic [ADDR_W:0] TOTAL_EXT    = (ADDR_W+1)'(TOTAL_PIXELS);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(TOTAL_PIXELS - 1);

    bank_state_t       bank_q [2];
    bank_state_t       bank_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_last_q, out_last_d;
    logic              drop_q, drop_d;
`ifdef FMAP_PINGPONG_STATS_EN
    logic [15:0]       frames_q, frames_d;
    logic [15:0]       drops_q, drops_d;
`endif

    logic              in_ready;
    logic              in_range;
    logic              wr_en;
    logic              frame_done;
    logic              fire;
    logic              rd_release;
    logic              other_free;
    logic              wr_blocked;
    logic              ram_rd_en;
    logic [ADDR_W:0]   ram_rd_addr;
    logic [ADDR_W-1:0] next_addr;

    always_comb begin
        bank_d      = bank_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        rd_state_d  = rd_state_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        ram_rd_en   = 1'b0;
        ram_rd_addr = {rd_bank_q, out_addr_q};
        next_addr   = out_addr_q + ADDR_W'(1);

        in_ready   = (bank_q[wr_bank_q] == EMPTY) || (bank_q[wr_bank_q] == FILLING);
        in_range   = {1'b0, in_addr_i} < TOTAL_EXT;
        wr_en      = in_valid_i && in_ready && in_range;
        drop_d     = in_valid_i && !(in_ready && in_range);
        frame_done = wr_en && (in_addr_i == LAST_ADDR);
        fire       = out_valid_q && out_ready_i;
        rd_release = fire && out_last_q;

        case (rd_state_q)
            R_IDLE: begin
                if (bank_q[rd_bank_q] == FULL) begin
                    bank_d[rd_bank_q] = READING;
                    ram_rd_en         = 1'b1;
                    ram_rd_addr       = {rd_bank_q, {ADDR_W{1'b0}}};
                    out_valid_d       = 1'b1;
                    out_addr_d        = '0;
                    out_last_d        = (LAST_ADDR == '0);
                    rd_state_d        = R_FETCH;
                end
            end
            R_FETCH, R_STREAM: begin
                rd_state_d = R_STREAM;
                if (fire) begin
                    if (out_last_q) begin
                        out_valid_d       = 1'b0;
                        out_last_d        = 1'b0;
                        out_addr_d        = '0;
                        bank_d[rd_bank_q] = EMPTY;
                        rd_bank_d         = ~rd_bank_q;
                        rd_state_d        = R_IDLE;
                    end else begin
                        ram_rd_en   = 1'b1;
                        ram_rd_addr = {rd_bank_q, next_addr};
                        out_addr_d  = next_addr;
                        out_last_d  = (next_addr == LAST_ADDR);
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        if (wr_en) begin
            bank_d[wr_bank_q] = frame_done ? FULL : FILLING;
        end

        // A bank released by the reader this cycle counts as free, so a frame
        // completing at the same moment can move straight on without a stall.
        other_free = (bank_q[~wr_bank_q] == EMPTY) ||
                     (rd_release && (rd_bank_q != wr_bank_q));
        wr_blocked = frame_done || (bank_q[wr_bank_q] == FULL) ||
                     (bank_q[wr_bank_q] == READING);
        if (wr_blocked && other_free) begin
            wr_bank_d = ~wr_bank_q;
        end

`ifdef FMAP_PINGPONG_STATS_EN
        frames_d = frames_q;
        drops_d  = drops_q;
        if (rd_release && (frames_q != 16'hFFFF)) begin
            frames_d = frames_q + 16'd1;
        end
        if (drop_d && (drops_q != 16'hFFFF)) begin
            drops_d = drops_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bank_q      <= '{EMPTY, EMPTY};
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_state_q  <= R_IDLE;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            drop_q      <= 1'b0;
`ifdef FMAP_PINGPONG_STATS_EN
            frames_q    <= '0;
            drops_q     <= '0;
`endif
        end else begin
            bank_q      <= bank_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            rd_state_q  <= rd_state_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            drop_q      <= drop_d;
`ifdef FMAP_PINGPONG_STATS_EN
            frames_q    <= frames_d;
            drops_q     <= drops_d;
`endif
        end
    end

    // Bank bit is the address MSB, so each bank spans a power-of-two half;
    // entries above TOTAL_PIXELS in each half are never addressed.
    ram_simple_dual_one_clock #(
        .WIDTH     (DATA_W),
        .SIZE      (2 ** (ADDR_W + 1)),
        .ADDRWIDTH (ADDR_W + 1)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (wr_en),
        .wr_addr_i ({wr_bank_q, in_addr_i}),
        .wr_data_i (in_data_i),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (ram_rd_addr),
        .rd_data_o (out_data_o)
    );

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign out_addr_o  = out_addr_q;
    assign out_last_o  = out_last_q;
    assign drop_o      = drop_q;
`ifdef FMAP_PINGPONG_STATS_EN
    assign frames_out_o = frames_q;
    assign drops_o      = drops_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fmap_pingpong_buffer.sv
// ============================================================================
//  Module      : tb_fmap_pingpong_buffer
//  Description : Randomised bench for fmap_pingpong_buffer with a frame-level
//                reference model (frame queue, bank contents, read schedule).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fmap_pingpong_buffer;

    localparam int TOT = 29 * 13;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       in_valid_i = 1'b0;
    logic [7:0] in_data_i = '0;
    logic [8:0] in_addr_i = '0;
    logic       in_ready_o;
    logic       out_valid_o;
    logic [7:0] out_data_o;
    logic [8:0] out_addr_o;
    logic       out_last_o;
    logic       out_ready_i = 1'b0;
    logic       drop_o;
`ifdef FMAP_PINGPONG_STATS_EN
    logic [15:0] frames_out_o;
    logic [15:0] drops_o;
`endif

    fmap_pingpong_buffer dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_addr_i   (in_addr_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_addr_o  (out_addr_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
`ifdef FMAP_PINGPONG_STATS_EN
        .frames_out_o(frames_out_o),
        .drops_o     (drops_o),
`endif
        .drop_o      (drop_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of completed-but-unread frames (by completion
    // cycle), bank contents, and the beat index of the frame being replayed.
    logic [7:0] m_mem [2][TOT];
    int  m_cq[$];
    int  m_wr_cnt, m_rd_cnt, m_beat, m_last_fire, cyc;
    bit  m_stream, m_drop;

    // Stimulus generator state
    int         g_order [TOT];
    logic [7:0] g_data  [TOT];
    int  g_idx, g_frames_left, g_fcount, g_mode;
    bit  g_busy, g_shuffle, g_hold_last, g_toggle, g_tog;
    int  g_pvalid, g_poor, g_pready, g_oor_force;

    // Observations of the DUT
    int  dut_drops, dut_beats, last_cnt, low_cnt, t_comp, t_first_valid;
    int  cap376;
    bit  sim_hit;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit m_ready();
        return m_cq.size() < 2;
    endfunction

    task automatic m_start_check();
        int t;
        if (!m_stream && m_cq.size() > 0) begin
            t = (m_cq[0] > m_last_fire) ? m_cq[0] : m_last_fire;
            if (cyc >= t + 2) begin
                m_stream = 1'b1;
                m_beat   = 0;
            end
        end
    endtask

    task automatic m_reset();
        m_cq.delete();
        m_wr_cnt = 0; m_rd_cnt = 0; m_beat = 0; m_last_fire = -10;
        m_stream = 1'b0; m_drop = 1'b0;
    endtask

    task automatic g_new_frame();
        int j, t;
        g_idx = 0;
        for (int i = 0; i < TOT; i++) g_order[i] = i;
        if (g_shuffle) begin
            for (int i = TOT - 2; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = g_order[i]; g_order[i] = g_order[j]; g_order[j] = t;
            end
        end
        for (int i = 0; i < TOT; i++) begin
            case (g_mode)
                1:       g_data[i] = 8'(g_order[i]);
                2:       g_data[i] = 8'(g_fcount + 1);
                default: g_data[i] = 8'($urandom);
            endcase
        end
    endtask

    task automatic g_start(input int frames, input int mode, input bit shuffle);
        g_frames_left = frames; g_mode = mode; g_shuffle = shuffle;
        g_fcount = 0; g_busy = 1'b1;
        g_new_frame();
    endtask

    // One clock cycle: compare, drive, advance the model, wait for the edge.
    task automatic step();
        bit iv, ordy, acc, fire, gen;
        logic [8:0] ia;
        logic [7:0] id;
        int pix;
        chk("in_ready", in_ready_o, m_ready());
        chk("out_valid", out_valid_o, m_stream);
        chk("drop", drop_o, m_drop);
        if (m_stream) begin
            chk("out_addr", out_addr_o, m_beat);
            chk("out_data", out_data_o, m_mem[m_rd_cnt % 2][m_beat]);
            chk("out_last", out_last_o, m_beat == TOT - 1);
        end
        if (drop_o) dut_drops++;
        if (!in_ready_o) low_cnt++;
        if (out_valid_o && t_first_valid < 0) t_first_valid = cyc;
        if (out_valid_o && out_addr_o == 9'd376) cap376 = out_data_o;

        iv = 1'b0; ia = '0; id = '0; gen = 1'b0;
        if (g_oor_force > 0) begin
            iv = 1'b1; ia = 9'd400; id = 8'($urandom); g_oor_force--;
        end else if (g_busy && $urandom_range(99, 0) < g_pvalid) begin
            pix = g_order[g_idx];
            if (!(g_hold_last && pix == TOT - 1 && !(m_stream && m_beat == TOT - 1))) begin
                iv = 1'b1; ia = 9'(pix); id = g_data[g_idx]; gen = 1'b1;
            end
        end else if ($urandom_range(99, 0) < g_poor) begin
            iv = 1'b1; ia = 9'($urandom_range(511, TOT)); id = 8'($urandom);
        end
        if (g_hold_last && gen && ia == 9'(TOT - 1)) ordy = 1'b1;
        else if (g_toggle) begin ordy = g_tog; g_tog = !g_tog; end
        else ordy = ($urandom_range(99, 0) < g_pready);
        in_valid_i = iv; in_addr_i = ia; in_data_i = id; out_ready_i = ordy;

        if (out_valid_o && ordy) begin
            dut_beats++;
            if (out_last_o) last_cnt++;
        end

        acc    = iv && m_ready() && (ia < TOT);
        m_drop = iv && !(m_ready() && (ia < TOT));
        fire   = m_stream && ordy;
        if (acc && ia == 9'(TOT - 1) && fire && m_beat == TOT - 1) sim_hit = 1'b1;
        if (gen && acc) begin
            g_idx++;
            if (g_idx == TOT) begin
                g_fcount++; g_frames_left--;
                if (g_frames_left > 0) g_new_frame();
                else g_busy = 1'b0;
            end
        end
        if (acc) begin
            m_mem[m_wr_cnt % 2][ia] = id;
            if (ia == 9'(TOT - 1)) begin
                m_cq.push_back(cyc); m_wr_cnt++; t_comp = cyc;
            end
        end
        if (fire) begin
            if (m_beat == TOT - 1) begin
                m_stream = 1'b0; void'(m_cq.pop_front()); m_rd_cnt++; m_last_fire = cyc;
            end else m_beat++;
        end
        @(negedge clk);
        cyc++;
        m_start_check();
    endtask

    function automatic bit done_cond(input int code, input int a);
        case (code)
            0:       return (m_wr_cnt >= a) && (m_rd_cnt >= a) && !g_busy;
            1:       return m_wr_cnt >= a;
            2:       return m_rd_cnt >= a;
            3:       return g_busy && (g_idx >= a);
            default: return m_stream && (m_beat >= a);
        endcase
    endfunction

    task automatic run_until(input string name, input int code, input int a, input int budget);
        for (int i = 0; i < budget && !done_cond(code, a); i++) step();
        chk({"wait_", name}, done_cond(code, a), 1);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        g_busy = 1'b0; g_oor_force = 0; g_hold_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_drop", drop_o, 0);
        rst_ni = 1'b1;
        m_reset();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, rb, d0;
        cyc = 0; g_toggle = 0; g_tog = 0; g_poor = 0; t_first_valid = -1;
        m_reset();
        do_reset();

        // Single sequential frame, data = addr[7:0], sink always ready
        g_pvalid = 100; g_pready = 100;
        g_start(1, 1, 1'b0);
        dut_beats = 0; last_cnt = 0; t_first_valid = -1; cap376 = -1;
        run_until("single", 0, 1, 2000);
        chk("first_valid_latency", t_first_valid - t_comp, 2);
        chk("single_beats", dut_beats, 377);
        chk("single_last_count", last_cnt, 1);
        chk("single_pix376_data", cap376, 120);

        // Backpressure: sink ready toggles every cycle
        g_toggle = 1'b1; dut_beats = 0;
        g_start(1, 0, 1'b1);
        run_until("backpressure", 0, 2, 3000);
        chk("bp_beats", dut_beats, 377);
        g_toggle = 1'b0;

        // Ping-pong: three frames with sink stalled
        wb = m_wr_cnt; rb = m_rd_cnt; g_pready = 0;
        g_start(3, 2, 1'b0);
        run_until("pp_two_frames", 1, wb + 2, 2000);
        chk("pp_ready_low", in_ready_o, 0);
        d0 = dut_drops;
        repeat (2) step();
        g_pvalid = 0;
        repeat (2) step();
        chk("pp_drop_pulses", dut_drops - d0, 2);
        g_pvalid = 100; g_pready = 100;
        run_until("pp_frame1_read", 2, rb + 1, 2000);
        chk("pp_ready_back", in_ready_o, 1);
        run_until("pp_done", 0, wb + 3, 3000);

        // Out-of-range address mid-frame
        wb = m_wr_cnt;
        g_start(1, 0, 1'b0);
        repeat (100) step();
        d0 = dut_drops; g_oor_force = 1;
        repeat (3) step();
        chk("oor_drop_pulse", dut_drops - d0, 1);
        run_until("oor_done", 0, wb + 1, 2000);

        // Randomised traffic
        wb = m_wr_cnt;
        g_pvalid = 70; g_poor = 5; g_pready = 60;
        g_start(6, 0, 1'b1);
        run_until("random", 0, wb + 6, 20000);
        g_poor = 0;

        // Reset at beat 100 of a read, then a fresh frame
        g_pvalid = 100; g_pready = 100;
        g_start(1, 0, 1'b0);
        run_until("reset_beat100", 4, 100, 2000);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid_o, 0);
        do_reset();
        g_start(1, 1, 1'b1);
        run_until("post_reset_frame", 0, 1, 2000);

        // Frame B completes on the same cycle frame A's last pixel fires
        wb = m_wr_cnt; g_pready = 0; sim_hit = 1'b0;
        g_start(2, 0, 1'b1);
        run_until("sim_frameA", 1, wb + 1, 1000);
        g_hold_last = 1'b1;
        run_until("sim_frameB_body", 3, TOT - 1, 1000);
        g_pready = 100; low_cnt = 0;
        run_until("sim_frameB_done", 1, wb + 2, 1000);
        chk("sim_same_cycle", sim_hit, 1);
        chk("sim_ready_low_cycles", low_cnt, 0);
        g_hold_last = 1'b0;
        run_until("sim_drain", 0, wb + 2, 1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
